// File: rtl/bram_responder.sv
// Responder for the mem_valid/mem_ready/mem_wstrb bus, backed by a word-wide block RAM with
// byte strobes, programmable wait states and an address-window check.
module bram_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        oor_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

  state_t         state;
  logic [3:0]     wait_cnt;
  logic           ram_issued;
  logic [AW-1:0]  lat_idx;
  logic [31:0]    lat_wdata;
  logic [3:0]     lat_wstrb;
  logic           lat_in_range;

  logic [31:0]    ram [DEPTH];
  logic [31:0]    ram_rd;
  logic           ram_en;

  logic [32:0]    win_lo;
  logic [32:0]    win_hi;
  logic           req_in_range;

  // 33-bit compare so a window ending at 4 GiB does not wrap.
  assign win_lo       = {1'b0, BASE_ADDR};
  assign win_hi       = win_lo + (33'(DEPTH) << 2);
  assign req_in_range = ({1'b0, mem_addr} >= win_lo) && ({1'b0, mem_addr} < win_hi);

  // RAM is touched exactly once per in-range access, on the edge the wait count runs out.
  assign ram_en = (state == StAccess) && (wait_cnt == 4'd0) && !ram_issued && lat_in_range;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) ram[i] = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_wstrb[i]) ram[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
      ram_rd <= ram[lat_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      wait_cnt     <= 4'd0;
      ram_issued   <= 1'b0;
      lat_idx      <= '0;
      lat_wdata    <= 32'h0;
      lat_wstrb    <= 4'h0;
      lat_in_range <= 1'b0;
      mem_ready    <= 1'b0;
      mem_rdata    <= 32'h0;
      oor_err      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          mem_ready <= 1'b0;
          oor_err   <= 1'b0;
          if (mem_valid) begin
            lat_idx      <= AW'((mem_addr - BASE_ADDR) >> 2);
            lat_wdata    <= mem_wdata;
            lat_wstrb    <= mem_wstrb;
            lat_in_range <= req_in_range;
            wait_cnt     <= 4'(WAIT_STATES);
            ram_issued   <= 1'b0;
            state        <= StAccess;
          end
        end
        StAccess: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (!ram_issued) begin
            ram_issued <= 1'b1;
          end else begin
            // Read data arrives one edge after the RAM is addressed.
            mem_ready <= 1'b1;
            oor_err   <= !lat_in_range;
            mem_rdata <= (lat_in_range && (lat_wstrb == 4'h0)) ? ram_rd : 32'h0;
            state     <= StResp;
          end
        end
        StResp: begin
          mem_ready <= 1'b0;
          oor_err   <= 1'b0;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
